// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants and FSM state type for the ALU opcode sequencer
//
// Purpose : default datapath widths and the 3-bit sequencer state encoding, shared by
//           the sequencer RTL and anything that talks to the ALU.
// Ports   : none (package).

package alu_seq_pkg;

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_OPW           = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4,
    ST_FIN     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_settle_cnt.sv
// rtl/alu_settle_cnt.sv - loadable down-counter timing the ALU settle window
//
// Purpose : counts the cycles the ALU inputs are held stable before capture.
// Ports   :
//   i_clk   in  clock, rising edge
//   i_rst   in  synchronous active-high reset (count cleared)
//   i_load  in  load the settle window (takes priority over i_dec)
//   i_dec   in  count down one step, saturating at zero
//   o_zero  out count is zero: the current cycle is the last settle cycle

module alu_settle_cnt #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Loaded with N-1 so that the zero flag marks the N-th settle cycle,
  // letting the FSM leave SETTLE on that same edge.
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - opcode-sweep engine wrapped around the combinational ALU
//
// Purpose : on start, latches operands and an opcode range, then for each opcode drives
//           the ALU, waits SETTLE_CYCLES, captures result/carry/product and offers it on
//           a valid/ready response stream. Ends each sweep with a done pulse (plus err
//           when the range was empty, op_first > op_last).
// Ports   :
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start                           begin sweep (sampled only when idle)
//   i_op1, i_op2                      operands, latched on accepted start
//   i_op_first, i_op_last             opcode range, latched on accepted start
//   o_alu_operand1/2, o_alu_opcode    registered ALU inputs
//   i_alu_result/carry_out/product    ALU outputs
//   o_resp_valid, i_resp_ready        response handshake
//   o_resp_opcode/result/carry/product captured response fields
//   o_busy                            high whenever the engine is not idle
//   o_done, o_err                     end-of-sweep pulse, empty-range flag

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int OPW           = DEF_OPW,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  input  logic [OPW-1:0]     i_op_first,
  input  logic [OPW-1:0]     i_op_last,
  output logic [WIDTH-1:0]   o_alu_operand1,
  output logic [WIDTH-1:0]   o_alu_operand2,
  output logic [OPW-1:0]     o_alu_opcode,
  input  logic [WIDTH-1:0]   i_alu_result,
  input  logic               i_alu_carry_out,
  input  logic [2*WIDTH-1:0] i_alu_product,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [OPW-1:0]     o_resp_opcode,
  output logic [WIDTH-1:0]   o_resp_result,
  output logic               o_resp_carry,
  output logic [2*WIDTH-1:0] o_resp_product,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  seq_state_e         r_state;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic [OPW-1:0]     r_op_last;
  logic [OPW-1:0]     r_cur_op;
  logic               r_range_err;

  logic [WIDTH-1:0]   r_alu_operand1;
  logic [WIDTH-1:0]   r_alu_operand2;
  logic [OPW-1:0]     r_alu_opcode;
  logic               r_resp_valid;
  logic [OPW-1:0]     r_resp_opcode;
  logic [WIDTH-1:0]   r_resp_result;
  logic               r_resp_carry;
  logic [2*WIDTH-1:0] r_resp_product;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_cnt_load;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic               w_xfer;

  assign w_cnt_load = (r_state == ST_DRIVE);
  assign w_cnt_dec  = (r_state == ST_SETTLE);
  assign w_xfer     = r_resp_valid && i_resp_ready;

  alu_settle_cnt #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_op1          <= '0;
      r_op2          <= '0;
      r_op_last      <= '0;
      r_cur_op       <= '0;
      r_range_err    <= 1'b0;
      r_alu_operand1 <= '0;
      r_alu_operand2 <= '0;
      r_alu_opcode   <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_opcode  <= '0;
      r_resp_result  <= '0;
      r_resp_carry   <= 1'b0;
      r_resp_product <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op1     <= i_op1;
            r_op2     <= i_op2;
            r_op_last <= i_op_last;
            r_busy    <= 1'b1;
            if (i_op_first > i_op_last) begin
              // Empty range: skip straight to FIN, no response is ever offered.
              r_range_err <= 1'b1;
              r_state     <= ST_FIN;
            end else begin
              r_range_err <= 1'b0;
              r_cur_op    <= i_op_first;
              r_state     <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          r_alu_operand1 <= r_op1;
          r_alu_operand2 <= r_op2;
          r_alu_opcode   <= r_cur_op;
          r_state        <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_resp_opcode  <= r_cur_op;
          r_resp_result  <= i_alu_result;
          r_resp_carry   <= i_alu_carry_out;
          r_resp_product <= i_alu_product;
          r_resp_valid   <= 1'b1;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          // Response fields and ALU inputs stay frozen until the consumer takes it.
          if (w_xfer) begin
            r_resp_valid <= 1'b0;
            if (r_cur_op == r_op_last) begin
              // Stop here rather than incrementing, so a range ending at the
              // top opcode never wraps back to zero.
              r_state <= ST_FIN;
            end else begin
              r_cur_op <= r_cur_op + OPW'(1);
              r_state  <= ST_DRIVE;
            end
          end
        end
        ST_FIN: begin
          r_done      <= 1'b1;
          r_err       <= r_range_err;
          r_range_err <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_operand1 = r_alu_operand1;
  assign o_alu_operand2 = r_alu_operand2;
  assign o_alu_opcode   = r_alu_opcode;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_opcode  = r_resp_opcode;
  assign o_resp_result  = r_resp_result;
  assign o_resp_carry   = r_resp_carry;
  assign o_resp_product = r_resp_product;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for the ALU opcode sequencer

module tb_alu_op_sequencer;

  localparam int W  = 32;
  localparam int OW = 4;
  localparam int SC = 2;

  typedef struct packed {
    logic          c;
    logic [W-1:0]  r;
    logic [2*W-1:0] p;
  } alu_t;

  typedef struct {
    logic [OW-1:0]  op;
    logic [W-1:0]   r;
    logic           c;
    logic [2*W-1:0] p;
  } resp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op1, op2;
  logic [OW-1:0]  op_first, op_last;
  logic [W-1:0]   alu_a, alu_b;
  logic [OW-1:0]  alu_op;
  logic [W-1:0]   alu_res;
  logic           alu_cy;
  logic [2*W-1:0] alu_prod;
  logic           resp_valid, resp_ready;
  logic [OW-1:0]  resp_opcode;
  logic [W-1:0]   resp_result;
  logic           resp_carry;
  logic [2*W-1:0] resp_product;
  logic           busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int hold_cnt = 0;
  int resp_valid_cycles = 0;

  resp_t exp_q[$];
  bit    done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.WIDTH(W), .OPW(OW), .SETTLE_CYCLES(SC)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_op1           (op1),
    .i_op2           (op2),
    .i_op_first      (op_first),
    .i_op_last       (op_last),
    .o_alu_operand1  (alu_a),
    .o_alu_operand2  (alu_b),
    .o_alu_opcode    (alu_op),
    .i_alu_result    (alu_res),
    .i_alu_carry_out (alu_cy),
    .i_alu_product   (alu_prod),
    .o_resp_valid    (resp_valid),
    .i_resp_ready    (resp_ready),
    .o_resp_opcode   (resp_opcode),
    .o_resp_result   (resp_result),
    .o_resp_carry    (resp_carry),
    .o_resp_product  (resp_product),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err)
  );

  // Behavioural stand-in for the combinational ALU.
  function automatic alu_t alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [OW-1:0] op);
    alu_t o;
    logic [W:0] t;
    o = '0;
    t = '0;
    case (op)
      4'd0:  begin t = {1'b0, a} + {1'b0, b}; o.r = t[W-1:0]; o.c = t[W]; end
      4'd1:  begin t = {1'b0, a} - {1'b0, b}; o.r = t[W-1:0]; o.c = t[W]; end
      4'd2:  o.r = a & b;
      4'd3:  o.r = a | b;
      4'd4:  o.r = a ^ b;
      4'd5:  o.r = ~(a & b);
      4'd6:  o.r = a << b[4:0];
      4'd7:  o.r = a >> b[4:0];
      4'd8:  begin o.p = 64'(a) * 64'(b); o.r = o.p[W-1:0]; end
      4'd9:  begin t = {1'b0, a} + 33'd1; o.r = t[W-1:0]; o.c = t[W]; end
      4'd10: begin t = {1'b0, a} - 33'd1; o.r = t[W-1:0]; o.c = t[W]; end
      4'd11: o.r = ~a;
      4'd12: o.r = {31'd0, a < b};
      4'd13: o.r = b;
      4'd14: begin t = {1'b0, a} + {1'b0, b} + 33'd1; o.r = t[W-1:0]; o.c = t[W]; end
      default: o.r = {a[W-2:0], a[W-1]};
    endcase
    if (op != 4'd8) o.p = {a ^ b, o.r};
    return o;
  endfunction

  alu_t alu_out;
  always_comb alu_out = alu_model(alu_a, alu_b, alu_op);
  assign alu_res  = alu_out.r;
  assign alu_cy   = alu_out.c;
  assign alu_prod = alu_out.p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_resp_valid"}, 64'(resp_valid), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_err"}, 64'(err), 0);
    check({tag, "_alu_in"}, {alu_a, alu_b} ^ 64'(alu_op), 0);
    check({tag, "_resp_fields"}, 64'(resp_opcode) | 64'(resp_result) | 64'(resp_carry), 0);
    check({tag, "_resp_product"}, resp_product, 0);
  endtask

  // Ready driver: always ready, random, or a 5-cycle stall on opcode 3.
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: resp_ready = 1'b1;
        1: resp_ready = ($urandom_range(0, 99) < 70);
        default: begin
          if (resp_valid && resp_opcode == 4'd3 && hold_cnt < 5) begin
            resp_ready = 1'b0;
            hold_cnt++;
          end else begin
            resp_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  bit             prev_stall = 0;
  bit             prev_xfer = 0;
  int             prev_xfer_cyc = 0;
  logic [OW-1:0]  s_op;
  logic [W-1:0]   s_r;
  logic           s_c;
  logic [2*W-1:0] s_p;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_xfer  = 0;
    end else begin
      if (resp_valid) begin
        resp_valid_cycles++;
        check("alu_opcode_held", 64'(alu_op), 64'(resp_opcode));
        check("busy_while_valid", 64'(busy), 1);
      end
      if (prev_stall) begin
        check("stall_valid_held", 64'(resp_valid), 1);
        check("stall_fields_held", {32'(resp_opcode), resp_result} ^ 64'(resp_carry),
              {32'(s_op), s_r} ^ 64'(s_c));
        check("stall_product_held", resp_product, s_p);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got opcode %0d expected no response", resp_opcode);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_opcode", 64'(resp_opcode), 64'(e.op));
          check("resp_result", 64'(resp_result), 64'(e.r));
          check("resp_carry", 64'(resp_carry), 64'(e.c));
          check("resp_product", resp_product, e.p);
        end
        if (prev_xfer && ready_mode == 0)
          check("op_period", 64'(cyc - prev_xfer_cyc), 64'(SC + 3));
        prev_xfer = 1;
        prev_xfer_cyc = cyc;
      end
      prev_stall = resp_valid && !resp_ready;
      s_op = resp_opcode;
      s_r  = resp_result;
      s_c  = resp_carry;
      s_p  = resp_product;
      if (done) begin
        prev_xfer = 0;
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          check("done_err", 64'(err), 64'(done_q.pop_front()));
        end
      end else if (err) begin
        check("err_without_done", 64'(err), 0);
      end
    end
  end

  // Issue a start, push the expected sweep, and count cycles until the watched event.
  task automatic start_measure(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [OW-1:0] f, input logic [OW-1:0] l,
                               input bit want_done, output int lat, output int busy_cycles);
    if (f <= l) begin
      for (int op = int'(f); op <= int'(l); op++) begin
        alu_t m;
        resp_t e;
        m = alu_model(a, b, OW'(op));
        e.op = OW'(op);
        e.r  = m.r;
        e.c  = m.c;
        e.p  = m.p;
        exp_q.push_back(e);
      end
    end
    done_q.push_back(f > l);
    op1 = a; op2 = b; op_first = f; op_last = l;
    start = 1'b1;
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      @(negedge clk);
      if (busy) busy_cycles++;
      if (want_done ? done : resp_valid) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 1);
    @(posedge clk);
    #1;
    check({tag, "_sb_drained"}, 64'(exp_q.size() + done_q.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, v0;
    logic [OW-1:0] f, l;
    rst = 1'b1; start = 1'b0;
    op1 = '0; op2 = '0; op_first = '0; op_last = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;

    // Full sweep 0..15 on (8,8) with latency measurement.
    ready_mode = 0;
    start_measure(32'd8, 32'd8, 4'd0, 4'd15, 0, lat, bc);
    check("first_resp_latency", 64'(lat), 64'(SC + 3));
    wait_done("full");

    // Backpressure on opcode 3 plus an ignored start while busy.
    ready_mode = 2;
    hold_cnt = 0;
    start_measure($urandom, $urandom, 4'd0, 4'd7, 0, lat, bc);
    op1 = $urandom; op2 = $urandom; op_first = 4'd12; op_last = 4'd14;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("bp");
    check("bp_stall_cycles", 64'(hold_cnt), 5);
    ready_mode = 0;

    // Invalid range: done+err at cycle 2, busy for one cycle, no responses.
    v0 = resp_valid_cycles;
    start_measure($urandom, $urandom, 4'd9, 4'd3, 1, lat, bc);
    check("invalid_done_cycle", 64'(lat), 2);
    check("invalid_busy_cycles", 64'(bc), 1);
    repeat (10) @(posedge clk);
    #1;
    check("invalid_no_resp", 64'(resp_valid_cycles - v0), 0);
    check("invalid_sb_drained", 64'(done_q.size()), 0);

    // Edge range 15..15: one response, no wrap.
    v0 = resp_valid_cycles;
    start_measure($urandom, $urandom, 4'd15, 4'd15, 0, lat, bc);
    wait_done("edge");
    repeat (20) @(posedge clk);
    #1;
    check("edge_valid_cycles", 64'(resp_valid_cycles - v0), 1);
    check("edge_idle", 64'(busy), 0);

    // Reset during opcode 6 settle, with a start in the reset cycle.
    start_measure($urandom, $urandom, 4'd4, 4'd10, 0, lat, bc);
    begin
      bit hit;
      hit = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (alu_op == 4'd6 && !resp_valid) begin
          hit = 1;
          break;
        end
      end
      check("reach_op6", 64'(hit), 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(negedge clk);
    check("start_with_rst_ignored", 64'(busy), 0);
    @(posedge clk);
    #1;
    start_measure($urandom, $urandom, 4'd4, 4'd10, 0, lat, bc);
    check("post_reset_latency", 64'(lat), 64'(SC + 3));
    wait_done("postreset");

    // Randomized sweeps with random backpressure.
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      f = OW'($urandom_range(0, 15));
      l = OW'($urandom_range(int'(f), 15));
      start_measure($urandom, $urandom, f, l, 0, lat, bc);
      wait_done("rand");
    end
    ready_mode = 0;

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
